// File: rtl/z80_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : z80_wb_pkg
// Description : Shared types and constants for the Z80 to Wishbone bridge.
// Revision    : 2.0 - second-generation bridge with mapper, I/O and errors
// ============================================================================
package z80_wb_pkg;

  // Bridge sequencer states, explicitly encoded
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Qualified Z80 bus cycle kinds
  typedef enum logic [2:0] {
    MEM_RD = 3'd0,
    MEM_WR = 3'd1,
    IO_RD  = 3'd2,
    IO_WR  = 3'd3,
    IACK   = 3'd4
  } cyc_t;

  // Byte handed to the CPU when a read ends in err or timeout
  localparam logic [7:0] ERR_RD_DATA = 8'hFF;

  function automatic logic cyc_is_rd(input cyc_t t);
    return (t == MEM_RD) || (t == IO_RD);
  endfunction

  function automatic logic cyc_is_wr(input cyc_t t);
    return (t == MEM_WR) || (t == IO_WR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/z80_page_mapper.sv
`default_nettype none
// ============================================================================
// Module      : z80_page_mapper
// Description : Four 16 KB page registers with a write port and a
//               combinational slot lookup. Resets to an identity map.
// Revision    : 2.0 - initial mapper for the second-generation bridge
// ============================================================================
module z80_page_mapper #(
  parameter int PAGE_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [1:0]        wsel_i,
  input  logic [PAGE_W-1:0] wdat_i,
  input  logic [1:0]        rsel_i,
  output logic [PAGE_W-1:0] page_o
);

  logic [PAGE_W-1:0] page_q [4];

  // Page registers: identity map on reset, single-slot update on write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        page_q[i] <= PAGE_W'(i);
      end
    end else if (we_i) begin
      page_q[wsel_i] <= wdat_i;
    end
  end

  // Lookup reflects the register contents before any same-edge write
  assign page_o = page_q[rsel_i];

endmodule
`default_nettype wire

// File: rtl/z80_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : z80_wb_bridge
// Description : Z80 bus strobes to Wishbone B4 classic master. Paged memory
//               window, separate I/O region, nWAIT stall, err/timeout abort,
//               refresh filtering and interrupt-acknowledge vector return.
// Revision    : 2.0 - mapper, I/O region, error handling, data direction
// ============================================================================
module z80_wb_bridge
  import z80_wb_pkg::*;
#(
  parameter int         PAGE_W   = 9,
  parameter int         IO_ADR_W = 16,
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] IACK_VEC = 8'hFF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [15:0]       z_a,
  input  logic [7:0]        z_do,
  output logic [7:0]        z_di,
  output logic              z_di_oe,
  input  logic              z_nmreq,
  input  logic              z_niorq,
  input  logic              z_nrd,
  input  logic              z_nwr,
  input  logic              z_nm1,
  input  logic              z_nrfsh,
  output logic              z_nwait,
  input  logic              map_we,
  input  logic [1:0]        map_sel,
  input  logic [PAGE_W-1:0] map_dat,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [PAGE_W+14:0] wb_adr_o,
  output logic [7:0]        wb_dat_o,
  input  logic [7:0]        wb_dat_i,
  output logic              wb_sel_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  output logic              bus_err_o
);

  localparam int ADR_W = PAGE_W + 15;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  cyc_t               typ_q, typ_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [7:0]         wdat_q, wdat_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic               sel_q, sel_d;
  logic [7:0]         di_q, di_d;
  logic               di_oe_q, di_oe_d;
  logic               berr_q, berr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               w_start;
  cyc_t               w_typ;
  logic               w_is_mem;
  logic               w_release;
  logic               w_tmo;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [PAGE_W-1:0]  w_page;
  logic [ADR_W-1:0]   w_mem_adr;
  logic [ADR_W-1:0]   w_io_adr;

  z80_page_mapper #(
    .PAGE_W (PAGE_W)
  ) u_mapper (
    .clk_i  (CLK),
    .rst_i  (RESET),
    .we_i   (map_we),
    .wsel_i (map_sel),
    .wdat_i (map_dat),
    .rsel_i (z_a[15:14]),
    .page_o (w_page)
  );

  assign w_mem_adr = {1'b0, w_page, z_a[13:0]};
  assign w_io_adr  = {1'b1, {(ADR_W-1-IO_ADR_W){1'b0}}, z_a[IO_ADR_W-1:0]};

  // Cycle qualification in priority order; refresh never qualifies
  always_comb begin
    w_start = 1'b1;
    w_typ   = MEM_RD;
    if (!z_nmreq && !z_nrd && z_nrfsh) begin
      w_typ = MEM_RD;
    end else if (!z_nmreq && !z_nwr) begin
      w_typ = MEM_WR;
    end else if (!z_niorq && !z_nrd && z_nm1) begin
      w_typ = IO_RD;
    end else if (!z_niorq && !z_nwr) begin
      w_typ = IO_WR;
    end else if (!z_niorq && !z_nm1) begin
      w_typ = IACK;
    end else begin
      w_start = 1'b0;
    end
  end

  assign w_is_mem = (w_typ == MEM_RD) || (w_typ == MEM_WR);

  // Originating strobe pair fully released, so a held strobe never retriggers
  always_comb begin
    w_release = 1'b0;
    case (typ_q)
      MEM_RD:  w_release = z_nmreq & z_nrd;
      MEM_WR:  w_release = z_nmreq & z_nwr;
      IO_RD:   w_release = z_niorq & z_nrd;
      IO_WR:   w_release = z_niorq & z_nwr;
      IACK:    w_release = z_niorq & z_nm1;
      default: w_release = 1'b1;
    endcase
  end

  // Counter value for this stb cycle; abort when it reaches TIMEOUT
  assign w_cnt_nxt = (cnt_q == CNT_W'(TIMEOUT)) ? cnt_q : cnt_q + CNT_W'(1);
  assign w_tmo     = (w_cnt_nxt == CNT_W'(TIMEOUT));

  // Next-state logic for the sequencer and all registered outputs
  always_comb begin
    state_d = state_q;
    typ_d   = typ_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    di_d    = di_q;
    di_oe_d = di_oe_q;
    berr_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (w_start) begin
          typ_d = w_typ;
          if (w_typ == IACK) begin
            state_d = HOLD;
            di_d    = IACK_VEC;
            di_oe_d = 1'b1;
          end else begin
            state_d = REQ;
            adr_d   = w_is_mem ? w_mem_adr : w_io_adr;
            wdat_d  = z_do;
            cyc_d   = 1'b1;
            sel_d   = 1'b1;
            we_d    = cyc_is_wr(w_typ);
            cnt_d   = '0;
          end
        end
      end
      REQ: begin
        cnt_d = w_cnt_nxt;
        // err beats a simultaneous ack; a timeout yields to a real ack
        if (wb_err_i || (w_tmo && !wb_ack_i)) begin
          state_d = HOLD;
          cyc_d   = 1'b0;
          sel_d   = 1'b0;
          we_d    = 1'b0;
          berr_d  = 1'b1;
          if (cyc_is_rd(typ_q)) begin
            di_d    = ERR_RD_DATA;
            di_oe_d = 1'b1;
          end
        end else if (wb_ack_i) begin
          state_d = HOLD;
          cyc_d   = 1'b0;
          sel_d   = 1'b0;
          we_d    = 1'b0;
          if (cyc_is_rd(typ_q)) begin
            di_d    = wb_dat_i;
            di_oe_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (w_release) begin
          state_d = IDLE;
          di_oe_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any cycle in flight
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      typ_q   <= MEM_RD;
      adr_q   <= '0;
      wdat_q  <= '0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      di_q    <= '0;
      di_oe_q <= 1'b0;
      berr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      typ_q   <= typ_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      di_q    <= di_d;
      di_oe_q <= di_oe_d;
      berr_q  <= berr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Stall while waiting on Wishbone, including the qualifying cycle itself
  assign z_nwait = RESET |
                   ~((state_q == REQ) ||
                     ((state_q == IDLE) && w_start && (w_typ != IACK)));

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = wdat_q;
  assign z_di      = di_q;
  assign z_di_oe   = di_oe_q;
  assign bus_err_o = berr_q;

endmodule
`default_nettype wire

// File: tb/tb_z80_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_z80_wb_bridge
// Description : Self-checking bench for z80_wb_bridge with a scoreboard of
//               expected CPU-side and Wishbone-side results.
// Revision    : 2.0 - bench for the second-generation bridge
// ============================================================================
module tb_z80_wb_bridge;

  localparam int PAGE_W  = 9;
  localparam int TO      = 8;
  localparam int K_MRD   = 0;
  localparam int K_MWR   = 1;
  localparam int K_IRD   = 2;
  localparam int K_IWR   = 3;
  localparam int K_IACK  = 4;

  typedef struct {
    bit          bus;
    bit          rd;
    logic [23:0] adr;
    logic        we;
    logic [7:0]  wdat;
    logic [7:0]  rdat;
    logic        err;
    int          n;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [15:0]       z_a = '0;
  logic [7:0]        z_do = '0;
  logic [7:0]        z_di;
  logic              z_di_oe;
  logic              z_nmreq = 1'b1, z_niorq = 1'b1, z_nrd = 1'b1;
  logic              z_nwr = 1'b1, z_nm1 = 1'b1, z_nrfsh = 1'b1;
  logic              z_nwait;
  logic              map_we = 1'b0;
  logic [1:0]        map_sel = '0;
  logic [PAGE_W-1:0] map_dat = '0;
  logic              wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o;
  logic [23:0]       wb_adr_o;
  logic [7:0]        wb_dat_o;
  logic [7:0]        wb_dat_i = '0;
  logic              wb_ack_i = 1'b0, wb_err_i = 1'b0;
  logic              bus_err_o;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  logic [PAGE_W-1:0] map_m [4];

  z80_wb_bridge #(
    .PAGE_W   (PAGE_W),
    .IO_ADR_W (16),
    .TIMEOUT  (TO),
    .IACK_VEC (8'hFF)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .z_a       (z_a),
    .z_do      (z_do),
    .z_di      (z_di),
    .z_di_oe   (z_di_oe),
    .z_nmreq   (z_nmreq),
    .z_niorq   (z_niorq),
    .z_nrd     (z_nrd),
    .z_nwr     (z_nwr),
    .z_nm1     (z_nm1),
    .z_nrfsh   (z_nrfsh),
    .z_nwait   (z_nwait),
    .map_we    (map_we),
    .map_sel   (map_sel),
    .map_dat   (map_dat),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_adr_o  (wb_adr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_dat_i  (wb_dat_i),
    .wb_sel_o  (wb_sel_o),
    .wb_ack_i  (wb_ack_i),
    .wb_err_i  (wb_err_i),
    .bus_err_o (bus_err_o)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_strobes(input int kind);
    case (kind)
      K_MRD:   begin z_nmreq = 1'b0; z_nrd = 1'b0; end
      K_MWR:   begin z_nmreq = 1'b0; z_nwr = 1'b0; end
      K_IRD:   begin z_niorq = 1'b0; z_nrd = 1'b0; end
      K_IWR:   begin z_niorq = 1'b0; z_nwr = 1'b0; end
      default: begin z_niorq = 1'b0; z_nm1 = 1'b0; end
    endcase
  endtask

  task automatic idle_strobes();
    z_nmreq = 1'b1; z_niorq = 1'b1; z_nrd = 1'b1;
    z_nwr = 1'b1; z_nm1 = 1'b1; z_nrfsh = 1'b1;
  endtask

  task automatic map_write(input int slot, input logic [PAGE_W-1:0] val);
    @(negedge CLK);
    map_we = 1'b1; map_sel = 2'(slot); map_dat = val;
    @(negedge CLK);
    map_we = 1'b0;
    map_m[slot] = val;
  endtask

  // One CPU cycle: push the expectation, drive strobes, act as Wishbone slave,
  // then pop and compare when the CPU is released.
  task automatic do_cyc(input int kind, input logic [15:0] a, input logic [7:0] d,
                        input int ack_at, input int err_at, input logic [7:0] rdat,
                        input bit mw, input int ms, input logic [PAGE_W-1:0] mv);
    exp_t e;
    int   waits = 0;
    int   stbn  = 0;
    bit   seen  = 0;
    bit   done  = 0;
    int   t_ack, t_err;
    logic [23:0] oadr = '0;
    logic        owe  = 1'b0;
    logic [7:0]  odat = '0;

    e.bus  = (kind != K_IACK);
    e.rd   = (kind == K_MRD) || (kind == K_IRD) || (kind == K_IACK);
    e.adr  = (kind == K_MRD || kind == K_MWR) ? {1'b0, map_m[a[15:14]], a[13:0]}
                                              : {1'b1, 7'd0, a};
    e.we   = (kind == K_MWR) || (kind == K_IWR);
    e.wdat = d;
    t_ack  = (ack_at != 0) ? ack_at : 1000;
    t_err  = (err_at != 0) ? err_at : 1000;
    if (t_err <= t_ack && t_err <= TO) begin e.n = t_err; e.err = 1'b1; end
    else if (t_ack <= TO)              begin e.n = t_ack; e.err = 1'b0; end
    else                               begin e.n = TO;    e.err = 1'b1; end
    if (kind == K_IACK) begin e.n = 0; e.err = 1'b0; end
    e.rdat = (kind == K_IACK) ? 8'hFF : (e.err ? 8'hFF : rdat);
    sb_q.push_back(e);

    @(negedge CLK);
    z_a = a; z_do = d; wb_dat_i = rdat;
    set_strobes(kind);
    if (mw) begin map_we = 1'b1; map_sel = 2'(ms); map_dat = mv; end
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (z_nwait) begin
        done = 1;
      end else begin
        waits++;
        if (wb_cyc_o) begin
          stbn++;
          if (!seen) begin seen = 1; oadr = wb_adr_o; owe = wb_we_o; odat = wb_dat_o; end
          wb_ack_i = (stbn == ack_at);
          wb_err_i = (stbn == err_at);
        end
        @(negedge CLK);
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        if (map_we) begin map_we = 1'b0; map_m[ms] = mv; end
      end
    end
    if (map_we) begin
      @(negedge CLK);
      map_we = 1'b0; map_m[ms] = mv;
      #1;
    end
    chk("cycle_finished", 32'(done), 32'd1);

    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("wait_cycles", waits, e.bus ? e.n + 1 : 0);
      chk("saw_wb_cycle", 32'(seen), 32'(e.bus));
      if (e.bus) begin
        chk("stb_cycles", stbn, e.n);
        chk("wb_adr", oadr, e.adr);
        chk("wb_we", 32'(owe), 32'(e.we));
        if (e.we) chk("wb_dat_o", odat, e.wdat);
        chk("bus_err_pulse", 32'(bus_err_o), 32'(e.err));
      end
      @(negedge CLK); #1;
      chk("cyc_dropped", 32'(wb_cyc_o), 32'd0);
      chk("stb_dropped", 32'(wb_stb_o), 32'd0);
      chk("bus_err_one_cycle", 32'(bus_err_o), 32'd0);
      chk("z_di_oe_hold", 32'(z_di_oe), 32'(e.rd));
      if (e.rd) chk("z_di", z_di, e.rdat);
      chk("nwait_hold", 32'(z_nwait), 32'd1);
    end
    idle_strobes();
    @(negedge CLK); #1;
    chk("z_di_oe_release", 32'(z_di_oe), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_cyc, saw_wait;
    for (int i = 0; i < 4; i++) map_m[i] = PAGE_W'(i);

    // Reset state
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_we", 32'(wb_we_o), 32'd0);
    chk("rst_sel", 32'(wb_sel_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_dat_o", wb_dat_o, 32'd0);
    chk("rst_z_di", z_di, 32'd0);
    chk("rst_z_di_oe", 32'(z_di_oe), 32'd0);
    chk("rst_nwait", 32'(z_nwait), 32'd1);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    @(negedge CLK);
    RESET = 1'b0;

    // Paged read with wait states
    map_write(1, 9'h055);
    do_cyc(K_MRD, 16'h4123, 8'h00, 3, 0, 8'hA5, 0, 0, '0);
    // I/O write, immediate ack
    do_cyc(K_IWR, 16'h7FFE, 8'h3C, 1, 0, 8'h00, 0, 0, '0);
    // Memory write through identity slot 3, I/O read
    do_cyc(K_MWR, 16'hC001, 8'h96, 2, 0, 8'h00, 0, 0, '0);
    do_cyc(K_IRD, 16'h0042, 8'h00, 1, 0, 8'h5A, 0, 0, '0);

    // Refresh is ignored
    @(negedge CLK);
    z_a = 16'h0055; z_nmreq = 1'b0; z_nrfsh = 1'b0;
    saw_cyc = 0; saw_wait = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      saw_cyc  |= wb_cyc_o;
      saw_wait |= !z_nwait;
      @(negedge CLK);
    end
    idle_strobes();
    chk("rfsh_no_cyc", 32'(saw_cyc), 32'd0);
    chk("rfsh_no_wait", 32'(saw_wait), 32'd0);
    // Interrupt acknowledge: vector, no wait, no Wishbone cycle
    do_cyc(K_IACK, 16'h0000, 8'h00, 0, 0, 8'h00, 0, 0, '0);

    // Timeout, then simultaneous ack and err
    do_cyc(K_MRD, 16'h8005, 8'h00, 0, 0, 8'h77, 0, 0, '0);
    do_cyc(K_MRD, 16'h4200, 8'h00, 2, 2, 8'h11, 0, 0, '0);

    // Mapper write on the qualifying edge only affects the following cycle
    do_cyc(K_MRD, 16'h0010, 8'h00, 1, 0, 8'h22, 1, 0, 9'h1FF);
    do_cyc(K_MRD, 16'h0010, 8'h00, 1, 0, 8'h33, 0, 0, '0);

    // Asynchronous reset in the middle of a request
    @(negedge CLK);
    z_a = 16'h4123;
    set_strobes(K_MRD);
    repeat (3) @(negedge CLK);
    #1;
    chk("pre_rst_cyc", 32'(wb_cyc_o), 32'd1);
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("arst_stb", 32'(wb_stb_o), 32'd0);
    chk("arst_z_di_oe", 32'(z_di_oe), 32'd0);
    chk("arst_nwait", 32'(z_nwait), 32'd1);
    for (int i = 0; i < 4; i++) map_m[i] = PAGE_W'(i);
    @(negedge CLK);
    idle_strobes();
    @(negedge CLK);
    RESET = 1'b0;
    wb_ack_i = 1'b1;
    @(negedge CLK);
    wb_ack_i = 1'b0;
    #1;
    chk("stray_ack_cyc", 32'(wb_cyc_o), 32'd0);
    chk("stray_ack_nwait", 32'(z_nwait), 32'd1);
    chk("stray_ack_oe", 32'(z_di_oe), 32'd0);
    do_cyc(K_MRD, 16'h4123, 8'h00, 2, 0, 8'hC3, 0, 0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
